// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter for the register-file write port plus a
// pending-write scoreboard for RAW stalls. Define RF_WB_STATS_EN to add conflict_cnt.
module rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_rd,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_rd,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic [ADDR_WIDTH-1:0] chk_rs1,
    input  logic [ADDR_WIDTH-1:0] chk_rs2,
    output logic                  chk_busy1,
    output logic                  chk_busy2,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_rd,
    output logic [DATA_WIDTH-1:0] rf_dataD
`ifdef RF_WB_STATS_EN
    ,
    output logic [31:0]           conflict_cnt
`endif
);
    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic                  prio_q, prio_d;
    logic                  grant0, grant1, accept;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_rd_q, rf_rd_d;
    logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;

    // Grant logic looks only at the valids and the pointer, never at rd/data.
    always_comb begin
        grant0   = req0_valid && (!req1_valid || !prio_q);
        grant1   = req1_valid && (!req0_valid || prio_q);
        accept   = grant0 || grant1;
        sel_rd   = grant1 ? req1_rd : req0_rd;
        sel_data = grant1 ? req1_data : req0_data;

        prio_d = prio_q;
        if (grant0) begin
            prio_d = 1'b1;
        end else if (grant1) begin
            prio_d = 1'b0;
        end

        rf_wen_d  = accept && (sel_rd != '0);
        rf_rd_d   = accept ? sel_rd : rf_rd_q;
        rf_data_d = accept ? sel_data : rf_data_q;
    end

    // A same-edge set beats the commit clear: the new producer owns the register.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
        if (gi == 0) begin : g_zero
            assign busy_d[gi] = 1'b0;
        end else begin : g_bit
            logic set_hit, clr_hit;
            assign set_hit    = issue_valid && (issue_rd == ADDR_WIDTH'(gi));
            assign clr_hit    = rf_wen_q && (rf_rd_q == ADDR_WIDTH'(gi));
            assign busy_d[gi] = set_hit || (busy_q[gi] && !clr_hit);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q    <= 1'b0;
            rf_wen_q  <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
            busy_q    <= '0;
        end else begin
            prio_q    <= prio_d;
            rf_wen_q  <= rf_wen_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
            busy_q    <= busy_d;
        end
    end

`ifdef RF_WB_STATS_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (req0_valid && req1_valid && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign conflict_cnt = cnt_q;
`endif

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign chk_busy1  = busy_q[chk_rs1];
    assign chk_busy2  = busy_q[chk_rs2];
    assign rf_wen     = rf_wen_q;
    assign rf_rd      = rf_rd_q;
    assign rf_dataD   = rf_data_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the arbiter and scoreboard.
module tb_rf_wb_arbiter;
    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid, issue_valid;
    logic [4:0]  req0_rd, req1_rd, issue_rd, chk_rs1, chk_rs2;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready, chk_busy1, chk_busy2;
    logic        rf_wen;
    logic [4:0]  rf_rd;
    logic [31:0] rf_dataD;
`ifdef RF_WB_STATS_EN
    logic [31:0] conflict_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: who is preferred next, which registers await a write,
    // and what the write port should be presenting.
    int          m_pref;
    int          m_last_g;
    bit          m_busy [32];
    bit          m_wen;
    int          m_rd;
    logic [31:0] m_data;
    logic [31:0] m_cnt;

    rf_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_dataD(rf_dataD)
`ifdef RF_WB_STATS_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        m_pref = 0;
        m_last_g = -1;
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
        m_wen = 0;
        m_rd = 0;
        m_data = '0;
        m_cnt = '0;
    endtask

    task automatic model_edge();
        int g = -1;
        int rd;
        logic [31:0] d;
        if (req0_valid && req1_valid) g = m_pref;
        else if (req0_valid) g = 0;
        else if (req1_valid) g = 1;
        if (req0_valid && req1_valid && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (m_wen) m_busy[m_rd] = 0;
        if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1;
        m_last_g = g;
        if (g >= 0) begin
            rd = (g == 0) ? int'(req0_rd) : int'(req1_rd);
            d  = (g == 0) ? req0_data : req1_data;
            m_pref = 1 - g;
            m_wen  = (rd != 0);
            m_rd   = rd;
            m_data = d;
            $display("txn: req%0d rd=%0d data=%08h", g, rd, d);
        end else begin
            m_wen = 0;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_rd = 0; req0_data = 0;
        req1_valid = 0; req1_rd = 0; req1_data = 0;
        issue_valid = 0; issue_rd = 0;
        chk_rs1 = 0; chk_rs2 = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        model_clear();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        step();
        checks++;
        if (rf_wen !== 1'b0 || rf_rd !== 5'd0 || rf_dataD !== 32'd0) begin
            errors++;
            $display("FAIL reset_out: wen=%b rd=%0d data=%08h, want 0/0/0", rf_wen, rf_rd, rf_dataD);
        end
`ifdef RF_WB_STATS_EN
        checks++;
        if (conflict_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d want 0", conflict_cnt);
        end
`endif
        for (int i = 0; i < 32; i++) begin
            chk_rs1 = 5'(i);
            chk_rs2 = 5'(31 - i);
            #1;
            checks++;
            if (chk_busy1 !== 1'b0 || chk_busy2 !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy[%0d]: busy1=%b busy2=%b want 0", i, chk_busy1, chk_busy2);
            end
        end
    endtask

    task automatic test_scoreboard();
        apply_reset();
        issue_valid = 1; issue_rd = 5;
        step();
        issue_valid = 0;
        chk_rs1 = 5;
        #1;
        checks++;
        if (chk_busy1 !== 1'b1) begin
            errors++;
            $display("FAIL sb_set: busy[5]=%b want 1", chk_busy1);
        end
        step();
        req0_valid = 1; req0_rd = 5; req0_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL sb_ready: got %b want 1", req0_ready);
        end
        step();
        req0_valid = 0;
        checks++;
        if (rf_wen !== 1'b1 || rf_rd !== 5'd5 || rf_dataD !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sb_write: wen=%b rd=%0d data=%08h want 1/5/deadbeef", rf_wen, rf_rd, rf_dataD);
        end
        checks++;
        if (chk_busy1 !== 1'b1) begin
            errors++;
            $display("FAIL sb_hold: busy[5]=%b want 1 until commit edge", chk_busy1);
        end
        step();
        checks++;
        if (chk_busy1 !== 1'b0 || rf_wen !== 1'b0) begin
            errors++;
            $display("FAIL sb_clear: busy[5]=%b wen=%b want 0/0", chk_busy1, rf_wen);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        req0_valid = 1; req0_rd = 1; req0_data = 32'hA1;
        req1_valid = 1; req1_rd = 2; req1_data = 32'hB2;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin
                errors++;
                $display("FAIL cont_ready[%0d]: r0=%b r1=%b want req%0d", k, req0_ready, req1_ready, k % 2);
            end
            step();
            checks++;
            if (rf_rd !== 5'(k + 1) || rf_wen !== 1'b1) begin
                errors++;
                $display("FAIL cont_order[%0d]: rd=%0d wen=%b want rd=%0d wen=1", k, rf_rd, rf_wen, k + 1);
            end
            if (k % 2 == 0) req0_rd = req0_rd + 2;
            else            req1_rd = req1_rd + 2;
        end
`ifdef RF_WB_STATS_EN
        checks++;
        if (conflict_cnt !== 32'd4) begin
            errors++;
            $display("FAIL cont_cnt: got %0d want 4", conflict_cnt);
        end
`endif
        idle_inputs();
    endtask

    task automatic test_req1_alone();
        apply_reset();
        req1_valid = 1;
        for (int k = 0; k < 3; k++) begin
            req1_rd = 5'(10 + k); req1_data = 32'(100 + k);
            #1;
            checks++;
            if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
                errors++;
                $display("FAIL alone_ready[%0d]: r0=%b r1=%b want 0/1", k, req0_ready, req1_ready);
            end
            step();
            checks++;
            if (rf_rd !== 5'(10 + k) || rf_dataD !== 32'(100 + k)) begin
                errors++;
                $display("FAIL alone_write[%0d]: rd=%0d data=%0d want %0d/%0d", k, rf_rd, rf_dataD, 10 + k, 100 + k);
            end
        end
        req1_rd = 13; req1_data = 113;
        req0_valid = 1; req0_rd = 20; req0_data = 120;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL alone_switch: r0=%b r1=%b want 1/0", req0_ready, req1_ready);
        end
        step();
        req0_valid = 0;
        checks++;
        if (rf_rd !== 5'd20) begin
            errors++;
            $display("FAIL alone_req0_first: rd=%0d want 20", rf_rd);
        end
        step();
        checks++;
        if (rf_rd !== 5'd13 || rf_wen !== 1'b1) begin
            errors++;
            $display("FAIL alone_req1_after: rd=%0d wen=%b want 13/1", rf_rd, rf_wen);
        end
        idle_inputs();
    endtask

    task automatic test_same_edge();
        apply_reset();
        issue_valid = 1; issue_rd = 7;
        step();
        issue_valid = 0;
        req0_valid = 1; req0_rd = 7; req0_data = 32'h77;
        step();
        req0_valid = 0;
        issue_valid = 1; issue_rd = 7;
        checks++;
        if (rf_wen !== 1'b1 || rf_rd !== 5'd7) begin
            errors++;
            $display("FAIL same_pre: wen=%b rd=%0d want 1/7", rf_wen, rf_rd);
        end
        step();
        issue_valid = 0;
        chk_rs2 = 7;
        #1;
        checks++;
        if (chk_busy2 !== 1'b1) begin
            errors++;
            $display("FAIL same_set_wins: busy[7]=%b want 1", chk_busy2);
        end
        req0_valid = 1; req0_rd = 0; req0_data = 32'h1;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL rd0_ready: got %b want 1", req0_ready);
        end
        step();
        req0_valid = 0;
        checks++;
        if (rf_wen !== 1'b0 || rf_rd !== 5'd0 || rf_dataD !== 32'h1 || chk_busy2 !== 1'b1) begin
            errors++;
            $display("FAIL rd0_nowrite: wen=%b rd=%0d data=%08h busy7=%b want 0/0/1/1", rf_wen, rf_rd, rf_dataD, chk_busy2);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        issue_valid = 1; issue_rd = 3;
        step();
        issue_valid = 0;
        req0_valid = 1; req0_rd = 3; req0_data = 32'h33;
        step();
        idle_inputs();
        chk_rs1 = 3;
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (rf_wen !== 1'b0 || rf_rd !== 5'd0 || rf_dataD !== 32'd0 || chk_busy1 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: wen=%b rd=%0d data=%08h busy3=%b want all 0", rf_wen, rf_rd, rf_dataD, chk_busy1);
        end
        #2;
        rst_n = 1;
        model_clear();
        step();
        checks++;
        if (rf_wen !== 1'b0 || chk_busy1 !== 1'b0) begin
            errors++;
            $display("FAIL mid_after: wen=%b busy3=%b want 0/0", rf_wen, chk_busy1);
        end
    endtask

    task automatic test_random();
        logic e0, e1;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            if (!req0_valid && $urandom_range(0, 2) != 0) begin
                req0_valid = 1; req0_rd = 5'($urandom); req0_data = $urandom;
            end
            if (!req1_valid && $urandom_range(0, 2) != 0) begin
                req1_valid = 1; req1_rd = 5'($urandom); req1_data = $urandom;
            end
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd = 5'($urandom);
            #1;
            e0 = req0_valid && (!req1_valid || m_pref == 0);
            e1 = req1_valid && (!req0_valid || m_pref == 1);
            checks++;
            if (req0_ready !== e0 || req1_ready !== e1) begin
                errors++;
                $display("FAIL rnd_ready[%0d]: r0=%b r1=%b want %b/%b", c, req0_ready, req1_ready, e0, e1);
            end
            step();
            if (m_last_g == 0) req0_valid = 0;
            if (m_last_g == 1) req1_valid = 0;
            checks++;
            if (rf_wen !== m_wen || rf_rd !== 5'(m_rd) || rf_dataD !== m_data) begin
                errors++;
                $display("FAIL rnd_port[%0d]: wen=%b rd=%0d data=%08h want %b/%0d/%08h",
                         c, rf_wen, rf_rd, rf_dataD, m_wen, m_rd, m_data);
            end
            chk_rs1 = 5'($urandom);
            chk_rs2 = 5'($urandom);
            #1;
            checks++;
            if (chk_busy1 !== m_busy[chk_rs1] || chk_busy2 !== m_busy[chk_rs2]) begin
                errors++;
                $display("FAIL rnd_busy[%0d]: rs1=%0d:%b rs2=%0d:%b want %b/%b", c, chk_rs1, chk_busy1,
                         chk_rs2, chk_busy2, m_busy[chk_rs1], m_busy[chk_rs2]);
            end
`ifdef RF_WB_STATS_EN
            checks++;
            if (conflict_cnt !== m_cnt) begin
                errors++;
                $display("FAIL rnd_cnt[%0d]: got %0d want %0d", c, conflict_cnt, m_cnt);
            end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        model_clear();
        test_reset();
        test_scoreboard();
        test_contention();
        test_req1_alone();
        test_same_edge();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
